// File: rtl/addsub_pipe.sv
// Pipelined signed adder/subtractor. The carry chain is cut into STAGES equal chunks,
// one chunk per cycle. ZF/SF/OF/CF are registered together with the result.
module addsub_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             cf
);
  localparam int C = WIDTH / STAGES;

  logic             r_vld [STAGES];
  logic             r_sub [STAGES];
  logic             r_cy  [STAGES];
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_s   [STAGES];
  logic             r_zf, r_sf, r_of, r_cf;

  logic             w_vld_in [STAGES];
  logic             w_sub_in [STAGES];
  logic             w_cin    [STAGES];
  logic [WIDTH-1:0] w_a_in   [STAGES];
  logic [WIDTH-1:0] w_b_in   [STAGES];
  logic [WIDTH-1:0] w_s_in   [STAGES];
  logic [WIDTH-1:0] w_s_out  [STAGES];
  logic             w_cy_out [STAGES];
  logic [C:0]       w_ck;
  logic [WIDTH-1:0] w_res;
  logic             w_adv, w_zf, w_sf, w_of, w_cf;

  assign w_adv     = ~r_vld[STAGES-1] | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_vld[STAGES-1];
  assign sum       = r_s[STAGES-1];
  assign zf        = r_zf;
  assign sf        = r_sf;
  assign of        = r_of;
  assign cf        = r_cf;

  // Stage 0 takes the ports (b inverted for SUB); later stages take the skewed registers.
  for (genvar k = 0; k < STAGES; k++) begin : g_src
    if (k == 0) begin : g_first
      assign w_vld_in[k] = in_valid;
      assign w_sub_in[k] = op_sub;
      assign w_cin[k]    = op_sub;
      assign w_a_in[k]   = a;
      assign w_b_in[k]   = op_sub ? ~b : b;
      assign w_s_in[k]   = {WIDTH{1'b0}};
    end else begin : g_next
      assign w_vld_in[k] = r_vld[k-1];
      assign w_sub_in[k] = r_sub[k-1];
      assign w_cin[k]    = r_cy[k-1];
      assign w_a_in[k]   = r_a[k-1];
      assign w_b_in[k]   = r_b[k-1];
      assign w_s_in[k]   = r_s[k-1];
    end
  end

  always_comb begin
    w_ck = {(C+1){1'b0}};
    for (int k = 0; k < STAGES; k++) begin
      w_ck = {1'b0, w_a_in[k][k*C +: C]} + {1'b0, w_b_in[k][k*C +: C]}
           + {{C{1'b0}}, w_cin[k]};
      w_s_out[k]            = w_s_in[k];
      w_s_out[k][k*C +: C]  = w_ck[C-1:0];
      w_cy_out[k]           = w_ck[C];
    end
  end

  // Flags use the completed result and the operands as seen by the last chunk.
  always_comb begin
    w_res = w_s_out[STAGES-1];
    w_zf  = (w_res == {WIDTH{1'b0}});
    w_sf  = w_res[WIDTH-1];
    w_of  = (w_a_in[STAGES-1][WIDTH-1] == w_b_in[STAGES-1][WIDTH-1]) &
            (w_res[WIDTH-1] != w_a_in[STAGES-1][WIDTH-1]);
    w_cf  = w_cy_out[STAGES-1] ^ w_sub_in[STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= 1'b0;
        r_sub[k] <= 1'b0;
        r_cy[k]  <= 1'b0;
        r_a[k]   <= {WIDTH{1'b0}};
        r_b[k]   <= {WIDTH{1'b0}};
        r_s[k]   <= {WIDTH{1'b0}};
      end
      r_zf <= 1'b0;
      r_sf <= 1'b0;
      r_of <= 1'b0;
      r_cf <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= w_vld_in[k];
        r_sub[k] <= w_sub_in[k];
        r_cy[k]  <= w_cy_out[k];
        r_a[k]   <= w_a_in[k];
        r_b[k]   <= w_b_in[k];
        r_s[k]   <= w_s_out[k];
      end
      r_zf <= w_zf;
      r_sf <= w_sf;
      r_of <= w_of;
      r_cf <= w_cf;
    end
  end
endmodule
